// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter for a single big-endian data memory port.
// Each access takes three cycles: IDLE (grant), ACCESS (enables high), RESP (ack).
module dmem_port_arbiter #(
   parameter int unsigned MEM_BYTES = 32,
   parameter int unsigned DATA_W    = 32
) (
   input  logic              CLK,
   input  logic              Reset,
   // CPU load/store port
   input  logic              c_req,
   input  logic              c_we,
   input  logic [31:0]       c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_ack,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_err,
   // debug / DMA loader port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   // data memory
   output logic              mem_Wren,
   output logic              mem_Read,
   output logic [31:0]       mem_DAddr,
   output logic [DATA_W-1:0] mem_Data,
   input  logic [DATA_W-1:0] mem_Mout
);

   localparam int unsigned ADDR_W    = 32;
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                gnt_d_q, gnt_d_d;        // winner of current access: 1 = port D
   logic                last_d_q, last_d_d;      // last granted port: 1 = port D
   logic                illegal_q, illegal_d;
   logic                wren_q, wren_d;
   logic                read_q, read_d;
   logic [ADDR_W-1:0]   daddr_q, daddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                c_ack_q, c_ack_d;
   logic                c_err_q, c_err_d;
   logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
   logic                d_ack_q, d_ack_d;
   logic                d_err_q, d_err_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   // Winner selection and payload mux for a grant taken in IDLE
   logic                sel_d_c;
   logic                sel_we_c;
   logic [ADDR_W-1:0]   sel_addr_c;
   logic [DATA_W-1:0]   sel_wdata_c;
   logic                sel_legal_c;

   // Pick the winner: sole requester, or on a tie the port not granted last
   always_comb begin
      sel_d_c     = d_req & (~c_req | ~last_d_q);
      sel_we_c    = sel_d_c ? d_we    : c_we;
      sel_addr_c  = sel_d_c ? d_addr  : c_addr;
      sel_wdata_c = sel_d_c ? d_wdata : c_wdata;
      sel_legal_c = (sel_addr_c[1:0] == 2'b00) && (sel_addr_c <= LAST_WORD);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      gnt_d_d   = gnt_d_q;
      last_d_d  = last_d_q;
      illegal_d = illegal_q;
      wren_d    = wren_q;
      read_d    = read_q;
      daddr_d   = daddr_q;
      wdata_d   = wdata_q;
      c_ack_d   = 1'b0;
      c_err_d   = 1'b0;
      c_rdata_d = c_rdata_q;
      d_ack_d   = 1'b0;
      d_err_d   = 1'b0;
      d_rdata_d = d_rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (c_req || d_req) begin
               gnt_d_d   = sel_d_c;
               last_d_d  = sel_d_c;
               daddr_d   = sel_addr_c;
               wdata_d   = sel_wdata_c;
               illegal_d = ~sel_legal_c;
               wren_d    = sel_legal_c & sel_we_c;
               read_d    = sel_legal_c & ~sel_we_c;
               state_d   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            wren_d = 1'b0;
            read_d = 1'b0;
            if (gnt_d_q) begin
               d_ack_d = 1'b1;
               d_err_d = illegal_q;
               if (illegal_q)   d_rdata_d = '0;
               else if (read_q) d_rdata_d = mem_Mout;
            end else begin
               c_ack_d = 1'b1;
               c_err_d = illegal_q;
               if (illegal_q)   c_rdata_d = '0;
               else if (read_q) c_rdata_d = mem_Mout;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            wren_d  = 1'b0;
            read_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         gnt_d_q   <= 1'b0;
         last_d_q  <= 1'b1;
         illegal_q <= 1'b0;
         wren_q    <= 1'b0;
         read_q    <= 1'b0;
         daddr_q   <= '0;
         wdata_q   <= '0;
         c_ack_q   <= 1'b0;
         c_err_q   <= 1'b0;
         c_rdata_q <= '0;
         d_ack_q   <= 1'b0;
         d_err_q   <= 1'b0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_d_q   <= gnt_d_d;
         last_d_q  <= last_d_d;
         illegal_q <= illegal_d;
         wren_q    <= wren_d;
         read_q    <= read_d;
         daddr_q   <= daddr_d;
         wdata_q   <= wdata_d;
         c_ack_q   <= c_ack_d;
         c_err_q   <= c_err_d;
         c_rdata_q <= c_rdata_d;
         d_ack_q   <= d_ack_d;
         d_err_q   <= d_err_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign c_ack     = c_ack_q;
   assign c_err     = c_err_q;
   assign c_rdata   = c_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_err     = d_err_q;
   assign d_rdata   = d_rdata_q;
   assign mem_Wren  = wren_q;
   assign mem_Read  = read_q;
   assign mem_DAddr = daddr_q;
   assign mem_Data  = wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, hand-written corner
// sequences, and randomized transactions against a transaction-level model.
module tb_dmem_port_arbiter;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic        c_ack, c_err, d_ack, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic        mem_Wren, mem_Read;
   logic [31:0] mem_DAddr, mem_Data, mem_Mout;

   dmem_port_arbiter #(.MEM_BYTES(32), .DATA_W(32)) dut (
      .CLK(CLK), .Reset(Reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_Wren(mem_Wren), .mem_Read(mem_Read), .mem_DAddr(mem_DAddr),
      .mem_Data(mem_Data), .mem_Mout(mem_Mout)
   );

   always #5 CLK = ~CLK;

   // Level-sensitive big-endian byte memory attached to the port
   logic [7:0] pmem [32] = '{default: 8'h00};
   logic [4:0] pa;
   assign pa       = mem_DAddr[4:0];
   assign mem_Mout = {pmem[pa], pmem[pa + 5'd1], pmem[pa + 5'd2], pmem[pa + 5'd3]};
   always @(posedge CLK) begin
      if (mem_Wren && mem_DAddr <= 32'd28) begin
         pmem[pa]        <= mem_Data[31:24];
         pmem[pa + 5'd1] <= mem_Data[23:16];
         pmem[pa + 5'd2] <= mem_Data[15:8];
         pmem[pa + 5'd3] <= mem_Data[7:0];
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   logic [7:0]  ref_mem [32] = '{default: 8'h00};
   logic        m_last_d;
   logic [31:0] m_crd, m_drd;

   function automatic logic is_legal(input logic [31:0] a);
      return (a % 4 == 0) && (a + 4 <= 32);
   endfunction

   task automatic model_reset();
      m_last_d = 1'b1;
      m_crd    = 32'h0;
      m_drd    = 32'h0;
   endtask

   task automatic model_apply(input logic is_d, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, output logic err);
      logic [31:0] rd;
      int          b;
      err = !is_legal(a);
      rd  = is_d ? m_drd : m_crd;
      if (err) rd = 32'h0;
      else begin
         b = int'(a);
         if (we) begin
            for (int i = 0; i < 4; i++) ref_mem[b + i] = 8'((wd >> (8 * (3 - i))) & 32'hFF);
         end else begin
            rd = 32'h0;
            for (int i = 0; i < 4; i++) rd = (rd << 8) | 32'(ref_mem[b + i]);
         end
      end
      if (is_d) m_drd = rd; else m_crd = rd;
      m_last_d = is_d;
   endtask

   // ---------------- driver / monitor ----------------
   int          r_n, r_wren, r_read;
   logic        r_port [2];
   int          r_k    [2];
   logic        r_err  [2];
   logic [31:0] r_crd  [2];
   logic [31:0] r_drd  [2];
   logic [31:0] r_daddr;

   task automatic run_txn(input logic rc, input logic rd, input logic cwe, input logic dwe,
                          input logic [31:0] ca, input logic [31:0] da,
                          input logic [31:0] cwd, input logic [31:0] dwd);
      int need;
      @(negedge CLK);
      c_req = rc; c_we = cwe; c_addr = ca; c_wdata = cwd;
      d_req = rd; d_we = dwe; d_addr = da; d_wdata = dwd;
      need = int'(rc) + int'(rd);
      r_n = 0; r_wren = 0; r_read = 0; r_daddr = 32'hX;
      for (int k = 1; k <= 14 && r_n < need; k++) begin
         @(negedge CLK);
         if (mem_Wren) r_wren++;
         if (mem_Read) r_read++;
         if (mem_Wren || mem_Read) r_daddr = mem_DAddr;
         chk("one_enable", 32'(mem_Wren & mem_Read), 32'h0);
         chk("one_ack", 32'(c_ack & d_ack), 32'h0);
         if (c_ack && r_n < 2) begin
            r_port[r_n] = 1'b0; r_k[r_n] = k; r_err[r_n] = c_err;
            r_crd[r_n] = c_rdata; r_drd[r_n] = d_rdata; r_n++; c_req = 1'b0;
         end
         if (d_ack && r_n < 2) begin
            r_port[r_n] = 1'b1; r_k[r_n] = k; r_err[r_n] = d_err;
            r_crd[r_n] = c_rdata; r_drd[r_n] = d_rdata; r_n++; d_req = 1'b0;
         end
      end
      if (r_n < need) begin
         chk("ack_timeout", 32'(r_n), 32'(need));
         c_req = 1'b0; d_req = 1'b0;
      end
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      Reset = 1'b1; c_req = 1'b0; d_req = 1'b0;
      repeat (2) @(negedge CLK);
      Reset = 1'b0;
      model_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        port_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic        err, first_d, rc, rd, cwe, dwe, ex_legal;
      logic [31:0] ca, da, cwd, dwd;
      int          exp_w, exp_r, acks, ack_k [4];
      logic        ack_p [4];
      logic [31:0] got, want;

      vecs[0] = '{1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 1'b0, 32'h04, 32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 32'h1C, 32'h12345678, 1'b0, 32'h0};
      vecs[3] = '{1'b1, 1'b0, 32'h1C, 32'h0,        1'b0, 32'h12345678};
      vecs[4] = '{1'b1, 1'b0, 32'h02, 32'h0,        1'b1, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h1C, 32'h0,        1'b0, 32'h12345678};
      vecs[6] = '{1'b1, 1'b0, 32'h1D, 32'h0,        1'b1, 32'h0};
      vecs[7] = '{1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 32'h0};
      vecs[8] = '{1'b0, 1'b1, 32'h03, 32'h0BADF00D, 1'b1, 32'h0};
      vecs[9] = '{1'b0, 1'b0, 32'h1C, 32'h0,        1'b0, 32'h12345678};

      Reset = 1'b1;
      c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      model_reset();
      repeat (3) @(negedge CLK);
      chk("rst_outputs", {23'h0, c_ack, c_err, d_ack, d_err, mem_Wren, mem_Read, 3'b0}, 32'h0);
      chk("rst_c_rdata", c_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_mem_DAddr", mem_DAddr, 32'h0);
      chk("rst_mem_Data", mem_Data, 32'h0);
      Reset = 1'b0;

      // Single-port vectors from reset
      foreach (vecs[i]) begin
         if (vecs[i].port_d)
            run_txn(1'b0, 1'b1, 1'b0, vecs[i].we, 32'h0, vecs[i].addr, 32'h0, vecs[i].wdata);
         else
            run_txn(1'b1, 1'b0, vecs[i].we, 1'b0, vecs[i].addr, 32'h0, vecs[i].wdata, 32'h0);
         model_apply(vecs[i].port_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, err);
         chk("vec_acks", 32'(r_n), 32'd1);
         chk("vec_port", 32'(r_port[0]), 32'(vecs[i].port_d));
         chk("vec_latency", 32'(r_k[0]), 32'd2);
         chk("vec_err", 32'(r_err[0]), 32'(vecs[i].exp_err));
         chk("vec_rdata", vecs[i].port_d ? r_drd[0] : r_crd[0], vecs[i].exp_rdata);
         chk("vec_wren", 32'(r_wren), (!vecs[i].exp_err && vecs[i].we) ? 32'd1 : 32'd0);
         chk("vec_read", 32'(r_read), (!vecs[i].exp_err && !vecs[i].we) ? 32'd1 : 32'd0);
         if (!vecs[i].exp_err) chk("vec_daddr", r_daddr, vecs[i].addr);
      end
      chk("mem_byte4", 32'(pmem[4]), 32'hDE);
      chk("mem_byte5", 32'(pmem[5]), 32'hAD);
      chk("mem_byte6", 32'(pmem[6]), 32'hBE);
      chk("mem_byte7", 32'(pmem[7]), 32'hEF);

      // Reset during ACCESS of a store: enable drops at once, no ack, no write
      @(negedge CLK);
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h08; c_wdata = 32'hAAAA5555;
      @(negedge CLK);
      chk("abort_wren_before", 32'(mem_Wren), 32'h1);
      Reset = 1'b1;
      #1;
      chk("abort_wren_drop", 32'(mem_Wren), 32'h0);
      chk("abort_daddr", mem_DAddr, 32'h0);
      c_req = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      model_reset();
      acks = 0;
      repeat (4) begin
         @(negedge CLK);
         if (c_ack || d_ack) acks++;
      end
      chk("abort_no_ack", 32'(acks), 32'h0);
      chk("abort_no_write", {pmem[8], pmem[9], pmem[10], pmem[11]}, 32'h0);

      // Both requests held continuously: C first after reset, then alternate
      @(negedge CLK);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h04;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1C;
      acks = 0;
      for (int k = 1; k <= 16 && acks < 4; k++) begin
         @(negedge CLK);
         chk("rr_one_ack", 32'(c_ack & d_ack), 32'h0);
         if ((c_ack || d_ack) && acks < 4) begin
            ack_p[acks] = d_ack; ack_k[acks] = k; acks++;
         end
      end
      c_req = 1'b0; d_req = 1'b0;
      chk("rr_ack_count", 32'(acks), 32'd4);
      for (int i = 0; i < 4 && i < acks; i++) begin
         chk("rr_grant", 32'(ack_p[i]), 32'(i % 2));
         chk("rr_ack_cycle", 32'(ack_k[i]), 32'(2 + 3 * i));
      end
      chk("rr_c_rdata", c_rdata, 32'hDEADBEEF);
      chk("rr_d_rdata", d_rdata, 32'h12345678);
      for (int i = 0; i < 4; i++)
         model_apply(i % 2 == 1, 1'b0, (i % 2 == 1) ? 32'h1C : 32'h04, 32'h0, err);

      // Address change during ACCESS is ignored
      @(negedge CLK);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h1C;
      @(negedge CLK);
      chk("mid_read", 32'(mem_Read), 32'h1);
      chk("mid_daddr_k1", mem_DAddr, 32'h1C);
      c_addr = 32'h04;
      @(negedge CLK);
      chk("mid_ack", 32'(c_ack), 32'h1);
      chk("mid_daddr_k2", mem_DAddr, 32'h1C);
      chk("mid_rdata", c_rdata, 32'h12345678);
      c_req = 1'b0;
      model_apply(1'b0, 1'b0, 32'h1C, 32'h0, err);

      // Randomized transactions against the reference model
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 2))
            0:       begin rc = 1'b1; rd = 1'b0; end
            1:       begin rc = 1'b0; rd = 1'b1; end
            default: begin rc = 1'b1; rd = 1'b1; end
         endcase
         cwe = 1'($urandom_range(0, 1));
         dwe = 1'($urandom_range(0, 1));
         for (int p = 0; p < 2; p++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
               0, 1:    a = 32'($urandom_range(0, 7)) * 32'd4;
               2:       a = 32'($urandom_range(0, 31));
               default: a = $urandom() | 32'h20;
            endcase
            if (p == 0) ca = a; else da = a;
         end
         cwd = $urandom();
         dwd = $urandom();
         first_d = (rc && rd) ? !m_last_d : rd;
         run_txn(rc, rd, cwe, dwe, ca, da, cwd, dwd);
         chk("rnd_acks", 32'(r_n), 32'(int'(rc) + int'(rd)));
         exp_w = 0; exp_r = 0;
         for (int i = 0; i < int'(rc) + int'(rd) && i < r_n; i++) begin
            logic pd;
            pd = (i == 0) ? first_d : !first_d;
            ex_legal = is_legal(pd ? da : ca);
            if (ex_legal && (pd ? dwe : cwe)) exp_w++;
            if (ex_legal && !(pd ? dwe : cwe)) exp_r++;
            model_apply(pd, pd ? dwe : cwe, pd ? da : ca, pd ? dwd : cwd, err);
            chk("rnd_port", 32'(r_port[i]), 32'(pd));
            chk("rnd_cycle", 32'(r_k[i]), 32'(2 + 3 * i));
            chk("rnd_err", 32'(r_err[i]), 32'(err));
            chk("rnd_c_rdata", r_crd[i], m_crd);
            chk("rnd_d_rdata", r_drd[i], m_drd);
         end
         chk("rnd_wren_cnt", 32'(r_wren), 32'(exp_w));
         chk("rnd_read_cnt", 32'(r_read), 32'(exp_r));
      end

      // Memory image written through the port matches the model
      @(negedge CLK);
      for (int w = 0; w < 8; w++) begin
         got  = {pmem[4*w], pmem[4*w+1], pmem[4*w+2], pmem[4*w+3]};
         want = {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};
         chk("final_mem_word", got, want);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_chk);
      $fatal(1);
   end

endmodule
